// File: rtl/ctrl_pkg.sv
// Shared types and sizes for the matrix-vector sequencer.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_WRITE,
        S_DONE,
        S_WAIT
    } ctrl_state_e;

    localparam int MAX_WIDTH = 64;
    localparam int BANK_BITS = 9;
    localparam int WIDTH_W   = 9;
    localparam int DIM_W     = 7;
    localparam int ITER_W    = 16;
    localparam int MADDR_W   = 12;
    localparam int VADDR_W   = 10;

    // Oversized requests run as the largest supported matrix.
    function automatic logic [DIM_W-1:0] clamp_width(input logic [WIDTH_W-1:0] w);
        return (w > WIDTH_W'(MAX_WIDTH)) ? DIM_W'(MAX_WIDTH) : w[DIM_W-1:0];
    endfunction

endpackage

// File: rtl/ctrl_delay_line.sv
// Fixed-depth shift register that lines MAC strobes up with the datapath latency.
module ctrl_delay_line #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign o_data = i_data;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_pipe [DEPTH];
            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
                logic [WIDTH-1:0] w_src;
                if (gi == 0) begin : g_head
                    assign w_src = i_data;
                end else begin : g_body
                    assign w_src = r_pipe[gi-1];
                end
                // Clearing drops strobes of an aborted job still in flight.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst)
                        r_pipe[gi] <= '0;
                    else if (i_clear)
                        r_pipe[gi] <= '0;
                    else
                        r_pipe[gi] <= w_src;
                end
            end
            assign o_data = r_pipe[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/mv_controller.sv
// Sequencer for y = M*x repeated 'iteration' times over ping-pong vector banks.
// Optional CTRL_PERF_CNT_EN adds the busy_cycles counter output.
module mv_controller
    import ctrl_pkg::*;
#(
    parameter int DELAY_MUL = 2,
    parameter int DELAY_ADD = 1,
    parameter int DELAY_ACC = 3,
    parameter int BRAM_LAT  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                running,
    input  logic [WIDTH_W-1:0]  width,
    input  logic [ITER_W-1:0]   iteration,
    output logic                mbram_clk,
    output logic                mbram_en,
    output logic [MADDR_W-1:0]  mbram_addr,
    output logic                vbram_clk,
    output logic                vbram_en,
    output logic                vbram_we,
    output logic [VADDR_W-1:0]  vbram_addr,
    output logic                zero_in,
    output logic                last,
    output logic                rows_over,
`ifdef CTRL_PERF_CNT_EN
    output logic [31:0]         busy_cycles,
`endif
    output logic                finish
);

    localparam int D      = BRAM_LAT + DELAY_MUL + DELAY_ADD + DELAY_ACC;
    localparam int A      = BRAM_LAT + DELAY_MUL + DELAY_ADD;
    localparam int DCNT_W = (D > 1) ? $clog2(D) : 1;
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(D - 1);

    ctrl_state_e         r_state, w_state_next;
    logic [DIM_W-1:0]    r_n, w_n_next;
    logic [DIM_W-1:0]    r_row, w_row_next;
    logic [DIM_W-1:0]    r_col, w_col_next;
    logic [ITER_W-1:0]   r_iter, w_iter_next;
    logic [ITER_W-1:0]   r_pass, w_pass_next;
    logic [MADDR_W-1:0]  r_maddr, w_maddr_next;
    logic [DCNT_W-1:0]   r_dcnt, w_dcnt_next;
    logic                w_zero_src, w_last_src, w_flush;
    logic [1:0]          w_strobe;

    assign mbram_clk = clk;
    assign vbram_clk = clk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_n     <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_iter  <= '0;
            r_pass  <= '0;
            r_maddr <= '0;
            r_dcnt  <= '0;
        end else begin
            r_state <= w_state_next;
            r_n     <= w_n_next;
            r_row   <= w_row_next;
            r_col   <= w_col_next;
            r_iter  <= w_iter_next;
            r_pass  <= w_pass_next;
            r_maddr <= w_maddr_next;
            r_dcnt  <= w_dcnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_n_next     = r_n;
        w_row_next   = r_row;
        w_col_next   = r_col;
        w_iter_next  = r_iter;
        w_pass_next  = r_pass;
        w_maddr_next = r_maddr;
        w_dcnt_next  = r_dcnt;
        w_zero_src   = 1'b0;
        w_last_src   = 1'b0;
        w_flush      = 1'b0;
        mbram_en     = 1'b0;
        mbram_addr   = '0;
        vbram_en     = 1'b0;
        vbram_we     = 1'b0;
        vbram_addr   = '0;
        rows_over    = 1'b0;
        finish       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (running) begin
                    if (width != '0 && iteration != '0) begin
                        w_state_next = S_READ;
                        w_n_next     = clamp_width(width);
                        w_iter_next  = iteration;
                        w_row_next   = '0;
                        w_col_next   = '0;
                        w_pass_next  = '0;
                        w_maddr_next = '0;
                    end else begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_READ: begin
                if (!running) begin
                    w_state_next = S_IDLE;
                    w_flush      = 1'b1;
                end else begin
                    mbram_en     = 1'b1;
                    mbram_addr   = r_maddr;
                    vbram_en     = 1'b1;
                    vbram_addr   = {r_pass[0], BANK_BITS'(r_col)};
                    w_zero_src   = (r_col == '0);
                    w_last_src   = (r_col == r_n - 7'd1);
                    w_maddr_next = r_maddr + 12'd1;
                    if (r_col == r_n - 7'd1) begin
                        w_state_next = S_DRAIN;
                        w_dcnt_next  = '0;
                    end else begin
                        w_col_next   = r_col + 7'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (!running) begin
                    w_state_next = S_IDLE;
                    w_flush      = 1'b1;
                end else if (r_dcnt == DCNT_LAST) begin
                    w_state_next = S_WRITE;
                end else begin
                    w_dcnt_next  = r_dcnt + 1'b1;
                end
            end
            S_WRITE: begin
                if (!running) begin
                    w_state_next = S_IDLE;
                    w_flush      = 1'b1;
                end else begin
                    // Results land in the bank opposite the one this pass reads.
                    vbram_en   = 1'b1;
                    vbram_we   = 1'b1;
                    vbram_addr = {~r_pass[0], BANK_BITS'(r_row)};
                    w_col_next = '0;
                    if (r_row == r_n - 7'd1) begin
                        rows_over    = 1'b1;
                        w_row_next   = '0;
                        w_maddr_next = '0;
                        w_pass_next  = r_pass + 16'd1;
                        w_state_next = (r_pass + 16'd1 == r_iter) ? S_DONE : S_READ;
                    end else begin
                        w_row_next   = r_row + 7'd1;
                        w_state_next = S_READ;
                    end
                end
            end
            S_DONE: begin
                finish       = 1'b1;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (!running)
                    w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    ctrl_delay_line #(
        .DEPTH (A),
        .WIDTH (2)
    ) u_strobe_dly (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_flush),
        .i_data  ({w_zero_src, w_last_src}),
        .o_data  (w_strobe)
    );

    assign {zero_in, last} = w_strobe;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] r_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_busy <= '0;
        else if (r_state == S_IDLE && w_state_next == S_READ)
            r_busy <= '0;
        else if (r_state == S_READ || r_state == S_DRAIN || r_state == S_WRITE)
            r_busy <= r_busy + 32'd1;
    end

    assign busy_cycles = r_busy;
`endif

endmodule

// File: tb/tb_mv_controller.sv
// Directed bench for mv_controller: traces each job and compares against hand-derived timing.
module tb_mv_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        running = 1'b0;
    logic [8:0]  width = '0;
    logic [15:0] iteration = '0;
    logic        mbram_clk, mbram_en, vbram_clk, vbram_en, vbram_we;
    logic [11:0] mbram_addr;
    logic [9:0]  vbram_addr;
    logic        zero_in, last, rows_over, finish;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] busy_cycles;
`endif

    mv_controller dut (
        .clk        (clk),
        .rst        (rst),
        .running    (running),
        .width      (width),
        .iteration  (iteration),
        .mbram_clk  (mbram_clk),
        .mbram_en   (mbram_en),
        .mbram_addr (mbram_addr),
        .vbram_clk  (vbram_clk),
        .vbram_en   (vbram_en),
        .vbram_we   (vbram_we),
        .vbram_addr (vbram_addr),
        .zero_in    (zero_in),
        .last       (last),
        .rows_over  (rows_over),
`ifdef CTRL_PERF_CNT_EN
        .busy_cycles(busy_cycles),
`endif
        .finish     (finish)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int q_mrd[$], q_vrd[$], q_vwr[$], q_vwr_cyc[$];
    int q_z[$], q_l[$], q_ro[$], q_fin[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Starts a job and records one cycle of activity per sample, stopping 2 cycles after finish.
    task automatic run_job(input logic [8:0] w, input logic [15:0] it, input int limit);
        q_mrd.delete(); q_vrd.delete(); q_vwr.delete(); q_vwr_cyc.delete();
        q_z.delete(); q_l.delete(); q_ro.delete(); q_fin.delete();
        @(negedge clk);
        width = w;
        iteration = it;
        running = 1'b1;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (mbram_en) q_mrd.push_back(int'(mbram_addr));
            if (vbram_en && !vbram_we) q_vrd.push_back(int'(vbram_addr));
            if (vbram_we) begin
                q_vwr.push_back(int'(vbram_addr));
                q_vwr_cyc.push_back(c);
            end
            if (zero_in) q_z.push_back(c);
            if (last) q_l.push_back(c);
            if (rows_over) q_ro.push_back(c);
            if (finish) q_fin.push_back(c);
            if (q_fin.size() > 0 && c >= q_fin[0] + 2) break;
        end
    endtask

    task automatic end_job();
        @(negedge clk);
        running = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    initial begin
        int e_vrd1[4]  = '{0, 1, 0, 1};
        int e_vrd2[8]  = '{0, 1, 0, 1, 512, 513, 512, 513};
        int e_vwr2[4]  = '{512, 513, 0, 1};
        int errs;
        int act;

        #1;
        chk("reset_outputs", {20'd0, mbram_en, vbram_en, vbram_we, zero_in, last,
                              rows_over, finish, mbram_addr == 0, vbram_addr == 0}, 32'd3);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // width=2, iteration=1
        run_job(9'd2, 16'd1, 40);
        chk("j1_mrd_count", q_mrd.size(), 4);
        for (int i = 0; i < 4; i++) chk("j1_maddr", at(q_mrd, i), i);
        for (int i = 0; i < 4; i++) chk("j1_vrd", at(q_vrd, i), e_vrd1[i]);
        chk("j1_wr0_addr", at(q_vwr, 0), 512);
        chk("j1_wr0_cyc", at(q_vwr_cyc, 0), 9);
        chk("j1_wr1_addr", at(q_vwr, 1), 513);
        chk("j1_wr1_cyc", at(q_vwr_cyc, 1), 19);
        chk("j1_rows_over_n", q_ro.size(), 1);
        chk("j1_rows_over_cyc", at(q_ro, 0), 19);
        chk("j1_finish_n", q_fin.size(), 1);
        chk("j1_finish_cyc", at(q_fin, 0), 20);
        chk("j1_zero0", at(q_z, 0), 4);
        chk("j1_zero1", at(q_z, 1), 14);
        chk("j1_last0", at(q_l, 0), 5);
        chk("j1_last1", at(q_l, 1), 15);
`ifdef CTRL_PERF_CNT_EN
        chk("j1_busy", busy_cycles, 20);
`endif
        // Held running must not restart the job.
        act = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (mbram_en || vbram_en || finish) act++;
        end
        chk("wait_no_restart", act, 0);
        end_job();

        // width=2, iteration=2: second pass swaps banks
        run_job(9'd2, 16'd2, 60);
        for (int i = 0; i < 8; i++) chk("j2_vrd", at(q_vrd, i), e_vrd2[i]);
        for (int i = 0; i < 4; i++) chk("j2_vwr", at(q_vwr, i), e_vwr2[i]);
        chk("j2_rows_over_n", q_ro.size(), 2);
        chk("j2_rows_over_cyc1", at(q_ro, 1), 39);
        chk("j2_finish_n", q_fin.size(), 1);
        chk("j2_finish_cyc", at(q_fin, 0), 40);
        end_job();

        // width=13, iteration=1: row cost 21
        run_job(9'd13, 16'd1, 300);
        chk("j3_mrd_count", q_mrd.size(), 169);
        errs = 0;
        for (int i = 0; i < q_mrd.size(); i++) if (q_mrd[i] != i) errs++;
        chk("j3_maddr_seq", errs, 0);
        chk("j3_maddr_last", at(q_mrd, 168), 168);
        chk("j3_zero_n", q_z.size(), 13);
        chk("j3_last_n", q_l.size(), 13);
        errs = 0;
        for (int r = 0; r < 13; r++) begin
            if (at(q_z, r) != r * 21 + 4) errs++;
            if (at(q_l, r) != r * 21 + 16) errs++;
        end
        chk("j3_strobe_align", errs, 0);
        chk("j3_finish_cyc", at(q_fin, 0), 273);
        end_job();

        // Degenerate jobs: finish only, no BRAM traffic
        run_job(9'd0, 16'd5, 10);
        chk("w0_finish_cyc", at(q_fin, 0), 0);
        chk("w0_no_access", q_mrd.size() + q_vrd.size() + q_vwr.size(), 0);
        end_job();
        run_job(9'd4, 16'd0, 10);
        chk("i0_finish_cyc", at(q_fin, 0), 0);
        chk("i0_no_access", q_mrd.size() + q_vrd.size() + q_vwr.size(), 0);
        end_job();

        // width=28 after a clean restart
        run_job(9'd28, 16'd1, 1100);
        chk("j28_mrd_count", q_mrd.size(), 784);
        chk("j28_wr_count", q_vwr.size(), 28);
        chk("j28_wr_last", at(q_vwr, 27), 539);
        chk("j28_rows_over_cyc", at(q_ro, 0), 1007);
        chk("j28_finish_cyc", at(q_fin, 0), 1008);
        end_job();

        // Abort during READ
        run_job(9'd5, 16'd1, 3);
        chk("abort_reads_before", q_mrd.size(), 3);
        running = 1'b0;
        act = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mbram_en || vbram_en || vbram_we || zero_in || last || rows_over || finish) act++;
        end
        chk("abort_quiet", act, 0);

        // width=70 clamps to 64, then reset mid-job
        run_job(9'd70, 16'd1, 80);
        chk("clamp_wr_cyc", at(q_vwr_cyc, 0), 71);
        chk("clamp_wr_addr", at(q_vwr, 0), 512);
        chk("clamp_row1_maddr", at(q_mrd, 64), 64);
        chk("clamp_mrd_count", q_mrd.size(), 72);
        chk("pre_reset_active", mbram_en, 1);
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", {mbram_en, vbram_en, vbram_we, zero_in, last, rows_over,
                                    finish, |mbram_addr, |vbram_addr}, 0);
        running = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
